// File: rtl/redc3329_from_mont.sv
`timescale 1ns/1ps
// Montgomery-exit converter for q=3329, R=2^12: out = in * R^-1 mod q, canonical 0..q-1.
// 3-stage valid/ready pipeline, 1 item/cycle; the whole pipe stalls while the output is held.
module redc3329_from_mont #(
  parameter int MOD     = 3329,
  parameter int MOD_INV = 3327,
  parameter int WIDTH   = 12,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SW = 2*WIDTH + 1;
  localparam logic [WIDTH-1:0] MINV_W = WIDTH'(MOD_INV);
  localparam logic [SW-1:0]    MOD_S  = SW'(MOD);
  localparam logic [WIDTH:0]   MOD_T  = (WIDTH+1)'(MOD);

  logic             stall;
  logic             advance;
  logic             in_fire;

  logic             v1, v2, v3;
  logic [WIDTH-1:0] x1, m1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [SW-1:0]    s2;
  logic [WIDTH-1:0] d3;

  logic [WIDTH-1:0] m_next;
  logic [SW-1:0]    s_next;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   t_red;
  logic [WIDTH-1:0] d3_next;

  assign stall    = v3 & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;
  assign in_fire  = in_valid & in_ready;

  // WIDTH x WIDTH product into WIDTH bits: keeps only the low bits, i.e. mod R.
  assign m_next  = in_data * MINV_W;
  assign s_next  = SW'(x1) + SW'(m1) * MOD_S;
  // Low WIDTH bits of s are zero by construction; t <= MOD so one subtract is enough.
  assign t       = (WIDTH+1)'(s2 >> WIDTH);
  assign t_red   = (t >= MOD_T) ? (t - MOD_T) : t;
  assign d3_next = WIDTH'(t_red);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      x1   <= '0;
      m1   <= '0;
      tag1 <= '0;
    end else if (advance) begin
      v1 <= in_fire;
      if (in_fire) begin
        x1   <= in_data;
        m1   <= m_next;
        tag1 <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      s2   <= '0;
      tag2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        s2   <= s_next;
        tag2 <= tag1;
      end
    end
  end

  // Data/tag only load with a real item so the output holds its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      d3   <= '0;
      tag3 <= '0;
    end else if (advance) begin
      v3 <= v2;
      if (v2) begin
        d3   <= d3_next;
        tag3 <= tag2;
      end
    end
  end

  assign out_valid = v3;
  assign out_data  = d3;
  assign out_tag   = tag3;
  assign busy      = v1 | v2 | v3;

  out_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ({1'b0, out_data} < MOD_T));

  out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)));

endmodule

// File: tb/tb_redc3329_from_mont.sv
`timescale 1ns/1ps
// Scoreboard bench for redc3329_from_mont: reference is a = x * R^-1 mod q with R^-1 = 2704.
module tb_redc3329_from_mont;

  localparam int Q     = 3329;
  localparam int RINV  = 2704;
  localparam int RMODQ = 767;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [7:0]  out_tag;
  logic        busy;

  redc3329_from_mont dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int d;
    int t;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  bit   sweep_done = 1'b0;

  bit pat [6] = '{1, 0, 1, 1, 0, 1};
  int pd  [6] = '{767, 0, 1, 3328, 0, 4095};
  int pe  [6] = '{1, 0, 2704, 625, 0, 626};

  function automatic int ref_model(input int x);
    return (x * RINV) % Q;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event required normal progress (t=%0t)", nm, $time);
  endtask

  // Holds the item on the input until it is accepted; the expectation is queued at accept time.
  task automatic send(input int x, input int tg, input int d, input bit lat);
    int   guard;
    bit   acc;
    exp_t e;
    guard = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = x[11:0];
    in_tag   = tg[7:0];
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        e.x = x; e.d = d; e.t = tg & 255; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 1000) begin
        fail("send_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    int   od;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          od = int'(out_data);
          chk("out_data", out_data, e.d);
          chk("out_tag", out_tag, e.t);
          chk("out_range", (od < Q) ? 1 : 0, 1);
          chk("out_inverse", (od * RMODQ) % Q, e.x % Q);
          if (e.lat) chk("latency", cyc - e.acc, 3);
          pops++;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p0;
    int  x;
    bit  obs [10];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    fork monitor(); join_none

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence: known values, latency and busy tail.
    send(767,  1, 1,    1);
    send(2385, 2, 767,  1);
    send(0,    3, 0,    1);
    send(1,    4, 2704, 1);
    send(3328, 5, 625,  1);
    send(4095, 6, 626,  1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_tail", busy, (k < 3) ? 1 : 0);
    end
    drain();

    // Tag integrity.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      x = $urandom_range(0, 4095);
      send(x, i, ref_model(x), 1);
    end
    drain();
    chk("tag_count", pops - p0, 16);

    // Backpressure: 4-cycle stall once the output is valid.
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int y;
          y = $urandom_range(0, 4095);
          send(y, 64 + i, ref_model(y), 0);
        end
      end
      begin
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (!out_valid && g < 100);
        if (!out_valid) fail("bp_wait_valid");
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          if (sb.size() > 0) begin
            chk("bp_hold_data", out_data, sb[0].d);
            chk("bp_hold_tag", out_tag, sb[0].t);
          end else begin
            fail("bp_sb_empty");
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", in_ready, 1);
      end
    join
    drain();
    chk("bp_count", pops - p0, 10);

    // Bubbles.
    for (int s = 0; s < 10; s++) begin
      if (s < 6) begin
        in_valid = pat[s];
        in_data  = pat[s] ? pd[s][11:0] : 12'($urandom_range(0, 4095));
        in_tag   = 8'(128 + s);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      obs[s] = out_valid;
      if (s < 6 && pat[s]) begin
        exp_t e;
        chk("bub_in_ready", in_ready, 1);
        e.x = pd[s]; e.d = pe[s]; e.t = 128 + s; e.acc = cyc; e.lat = 1'b1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) chk("bub_lead_idle", obs[i], 0);
    for (int i = 0; i < 6; i++) chk("bub_out_valid", obs[i+3], pat[i]);
    drain();

    // Reset with three items in flight.
    send(767,  161, 1,    0);
    send(2385, 162, 767,  0);
    send(1,    163, 2704, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    sb.delete();
    #20 rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle_valid", out_valid, 0);
    chk("post_rst_idle_busy", busy, 0);
    @(posedge clk); #1;

    // Exhaustive sweep with random downstream readiness.
    p0 = pops;
    sweep_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 4096; v++) send(v, v & 255, ref_model(v), 0);
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("sweep_count", pops - p0, 4096);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
